// File: rtl/mm_sched_pkg.sv
// Shared types and constants for the round-robin matrix-vector scheduler.
package mm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int TIMEOUT_DEFAULT = 31;

  // Width of a requester index; never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mm_scheduler_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer, wrapping.
module rr_arbiter
  import mm_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [idWidth(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic [idWidth(NUM_REQ)-1:0] o_idx,
  output logic                        o_any
);

  localparam int IDW = idWidth(NUM_REQ);

  logic [IDW-1:0] w_cand;
  logic           w_found;

  assign o_any = |i_req;

  // Walk the requesters starting at the pointer and keep the first valid one.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = IDW'((int'(i_ptr) + i) % NUM_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found = 1'b1;
        o_grant = NUM_REQ'(1) << w_cand;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/mm_scheduler.sv
// Shares one matrix-vector engine among several requesters, one job at a time, round-robin.
module mm_scheduler
  import mm_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ROWS       = 2,
  parameter int COLS       = 2,
  parameter int TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic [NUM_REQ-1:0]                                   req_valid,
  output logic [NUM_REQ-1:0]                                   req_ready,
  input  logic [NUM_REQ-1:0][ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] req_mat,
  input  logic [NUM_REQ-1:0][COLS-1:0][DATA_WIDTH-1:0]         req_vec,
  output logic                                                 rsp_valid,
  input  logic                                                 rsp_ready,
  output logic [idWidth(NUM_REQ)-1:0]                          rsp_id,
  output logic [ROWS-1:0][DATA_WIDTH-1:0]                      rsp_out,
  output logic                                                 rsp_err,
  output logic                                                 mm_start,
  output logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0]            mm_mat,
  output logic [COLS-1:0][DATA_WIDTH-1:0]                      mm_vec,
  input  logic [ROWS-1:0][DATA_WIDTH-1:0]                      mm_out,
  input  logic                                                 mm_done,
  output logic                                                 busy
);

  localparam int IDW = idWidth(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_t                                    r_state;
  state_t                                    w_nextState;
  logic [IDW-1:0]                            r_rrPtr;
  logic [IDW-1:0]                            w_grantIdx;
  logic [NUM_REQ-1:0]                        w_grant;
  logic                                      w_anyValid;
  logic                                      w_accept;
  logic                                      w_timeout;
  logic [CW-1:0]                             r_waitCnt;
  logic [ROWS-1:0][DATA_WIDTH-1:0]           r_rspOut;
  logic                                      r_rspErr;
  logic [IDW-1:0]                            r_rspId;
  logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] r_mmMat;
  logic [COLS-1:0][DATA_WIDTH-1:0]           r_mmVec;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .i_req  (req_valid),
    .i_ptr  (r_rrPtr),
    .o_grant(w_grant),
    .o_idx  (w_grantIdx),
    .o_any  (w_anyValid)
  );

  assign w_accept  = (r_state == IDLE) && w_anyValid;
  assign w_timeout = (r_waitCnt == CW'(TIMEOUT));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state decision; an engine done beats a simultaneous timeout.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_anyValid) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (mm_done || w_timeout) w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Job datapath: latch operands at grant, count WAIT cycles, capture result or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr   <= '0;
      r_waitCnt <= '0;
      r_rspOut  <= '0;
      r_rspErr  <= 1'b0;
      r_rspId   <= '0;
      r_mmMat   <= '0;
      r_mmVec   <= '0;
    end else begin
      if (w_accept) begin
        r_mmMat <= req_mat[w_grantIdx];
        r_mmVec <= req_vec[w_grantIdx];
        r_rspId <= w_grantIdx;
        r_rrPtr <= (w_grantIdx == IDW'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;
      end
      case (r_state)
        ISSUE: r_waitCnt <= '0;
        WAIT: begin
          if (mm_done) begin
            r_rspOut <= mm_out;
            r_rspErr <= 1'b0;
          end else if (w_timeout) begin
            r_rspOut <= '0;
            r_rspErr <= 1'b1;
          end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs decoded from state, all quiet while reset is held.
  always_comb begin
    req_ready = '0;
    mm_start  = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      req_ready = (r_state == IDLE) ? w_grant : '0;
      mm_start  = (r_state == ISSUE);
      rsp_valid = (r_state == RESP);
      busy      = (r_state != IDLE);
    end
  end

  assign rsp_out = r_rspOut;
  assign rsp_err = r_rspErr;
  assign rsp_id  = r_rspId;
  assign mm_mat  = r_mmMat;
  assign mm_vec  = r_mmVec;

endmodule
